// File: rtl/packer_pkg.sv
// Shared definitions for the lane packer and unpacker.
// Both sides use the same count-width rule and lane-extract helper, so
// they always agree on lane ordering (lane 0 in the least-significant bits).
package packer_pkg;

    // Widest packed word the lane-extract helper can handle.
    localparam int max_packed_width_c = 64;

    typedef logic [max_packed_width_c-1:0] packed_max_t;

    // Bits needed to hold a lane count from 0 up to packed_num inclusive.
    function automatic int count_width_f(input int packed_num);
        return $clog2(packed_num + 1);
    endfunction

    // Moves the selected lane down to bit 0.
    // The caller truncates the result to its own element width.
    function automatic packed_max_t lane_extract_f(input packed_max_t word,
                                                   input int          lane,
                                                   input int          width);
        return word >> (lane * width);
    endfunction

endpackage

// File: rtl/unpacker.sv
// Unpacker: serialises a packed word into narrow elements, lane 0 first.
// A short word is described by its lane count. The last element of a
// flushed word carries the flush marker downstream. Elements are read
// straight from the holding register, so there is no output stage.
module unpacker
    import packer_pkg::*;
#(
    parameter int unpacked_width_p = 2,
    parameter int packed_num_p     = 4,
    parameter int packed_width_p   = unpacked_width_p * packed_num_p,
    parameter int count_width_p    = count_width_f(packed_num_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [packed_width_p-1:0]   packed_i,
    input  logic [count_width_p-1:0]    count_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [unpacked_width_p-1:0] unpacked_o,
    output logic                        last_o,
    output logic                        flush_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam int lane_width_lp = $clog2(packed_num_p);
    localparam logic [count_width_p-1:0] num_count_lp = count_width_p'(packed_num_p);
    localparam logic [lane_width_lp-1:0] max_lane_lp  = lane_width_lp'(packed_num_p - 1);

    // Holding register for the word being emitted.
    logic [packed_width_p-1:0] word_r;
    logic                      flush_r;
    logic [lane_width_lp-1:0]  lane_r;
    logic [lane_width_lp-1:0]  end_r;
    logic                      busy_r;

    logic                      count_zero;
    logic [lane_width_lp-1:0]  end_in;
    logic                      at_last;
    logic                      in_fire;
    logic                      out_fire;

    // Final lane index of the incoming word. A count above the lane total is
    // clamped to a full word. A zero count is flagged so the word is dropped.
    always_comb begin
        count_zero = (count_i == '0);
        end_in     = max_lane_lp;
        if (count_i < num_count_lp) begin
            end_in = lane_width_lp'(count_i - 1'b1);
        end
    end

    assign at_last  = busy_r && (lane_r == end_r);
    assign ready_o  = !busy_r || (at_last && ready_i);
    assign in_fire  = valid_i && ready_o;
    assign out_fire = busy_r && ready_i;

    assign unpacked_o = unpacked_width_p'(lane_extract_f(packed_max_t'(word_r),
                                                         int'(lane_r),
                                                         unpacked_width_p));
    assign valid_o    = busy_r;
    assign last_o     = at_last;
    assign flush_o    = at_last && flush_r;

    // Step through the lanes of the held word. When the word is empty, or
    // its final lane is leaving, a new word is loaded in the same edge so
    // back-to-back words have no bubble between them.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            word_r  <= '0;
            flush_r <= 1'b0;
            lane_r  <= '0;
            end_r   <= '0;
            busy_r  <= 1'b0;
        end else if (out_fire && !at_last) begin
            lane_r <= lane_r + 1'b1;
        end else if (!busy_r || (out_fire && at_last)) begin
            if (in_fire && !count_zero) begin
                word_r  <= packed_i;
                flush_r <= flush_i;
                end_r   <= end_in;
                lane_r  <= '0;
                busy_r  <= 1'b1;
            end else if (out_fire) begin
                busy_r <= 1'b0;
            end
        end
    end

    // A stalled element stays valid and unchanged until it is taken.
    stall_stable_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
        (busy_r && !ready_i) |=> (busy_r && $stable(unpacked_o)));

    // The lane index never moves past the final lane of its word.
    lane_bound_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
        lane_r <= end_r);

    // The flush marker appears only on the final element of a word.
    flush_last_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
        flush_o |-> last_o);

endmodule

// File: doc/unpacker.md
# unpacker

Serialises packed words back into narrow elements, least-significant lane first. This block is the read side of the lane packing used on the capture path. A packed word arrives on a valid/ready interface with a lane count that marks short, flushed words. The block emits one `unpacked_width_p`-bit element per cycle, and the final element of a flushed word carries a flush marker downstream.

## Interface
- `unpacked_width_p`, default 2: width of one output element.
- `packed_num_p`, default 4: number of lanes per packed word; must be ≥ 2.
- `packed_width_p`, default `unpacked_width_p*packed_num_p`: input word width; not overridden.
- `count_width_p`, default `$clog2(packed_num_p+1)`: width of the lane-count field.
- `clk_i`  in  1  sole clock; all state on rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `packed_i`  in  `packed_width_p`  packed word; lane k sits at bits `[k*unpacked_width_p +: unpacked_width_p]`.
- `count_i`  in  `count_width_p`  number of valid lanes in `packed_i`, from lane 0 upward.
- `flush_i`  in  1  word ends a frame (it was produced by a flush).
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  word accepted when `valid_i && ready_o`.
- `unpacked_o`  out  `unpacked_width_p`  current element.
- `last_o`  out  1  current element is the final lane of its word.
- `flush_o`  out  1  equals `last_o && flush` of the word; high only on its final element.
- `valid_o`  out  1  element valid.
- `ready_i`  in  1  downstream accepts when `valid_o && ready_i`.

## Operation
- State is held in three registers:
  - Word register: `word_r`, `flush_r`.
  - Lane index: `lane_r`, width `$clog2(packed_num_p)`.
  - End index: `end_r` = effective count − 1.
  - A `busy_r` flag marks the word register as holding data.
- Effective count = `count_i` clamped to `packed_num_p`. If `count_i > packed_num_p`, the block treats it as `packed_num_p`; this is not an error.
- A word with `count_i == 0` is accepted and discarded: no element is produced and `busy_r` is unchanged. If `flush_i` is also set, the marker is dropped.
- Output signals, all combinational from registers:
  - `unpacked_o = word_r[lane_r*unpacked_width_p +: unpacked_width_p]`.
  - `valid_o = busy_r`.
  - `last_o = busy_r && lane_r == end_r`.
- `ready_o = !busy_r || (last_o && ready_i)`. There is no combinational path from `valid_i` to `ready_o`.
- On an output fire that is not the last lane: `lane_r` increments.
- On an output fire that is the last lane:
  - If a word fires on the same cycle, it is loaded, `lane_r` is set to 0 and `busy_r` stays 1.
  - Otherwise `busy_r` is cleared.
- On an input fire while `busy_r == 0` and the effective count is ≥ 1: load `word_r`, `flush_r`, `end_r`, set `lane_r = 0` and `busy_r = 1`.
- `unpacked_o` holds steady while `valid_o && !ready_i`. `valid_o` never drops without a fire.
- Reset mid-word: the partial word is lost and nothing is replayed.

## Timing
- Reset values:
  - `valid_o=0`, `last_o=0`, `flush_o=0`.
  - `unpacked_o=0`, because `word_r` is cleared.
  - `ready_o=1`.
- Latency: a word accepted at edge N presents lane 0 in the cycle after edge N.
- Throughput: a full word with `count = packed_num_p` occupies exactly `packed_num_p` cycles under continuous `ready_i`. Back-to-back words produce no bubble between the last lane of one and lane 0 of the next.
- Downstream stall (`ready_i=0`) on the last lane forces `ready_o=0` that cycle.
- `lane_r` never exceeds `end_r`, so there is no wrap-around past `packed_num_p-1`.

## Structure
- Shared package `packer_pkg` holds:
  - A count-width helper function `count_width_f(packed_num)`.
  - A lane-extract function, so the packer and unpacker agree on lane ordering.
- No sub-module: output is taken directly from the holding register. An `elastic` stage is added externally only if a timing fix is needed.
- Target size is roughly 150 lines of RTL, including assertions:
  - `valid_o` is stable under stall.
  - `lane_r <= end_r`.
  - `flush_o` implies `last_o`.

## Test plan
All scenarios use width=2 and num=4.
- Reset: hold `reset_ni=0` for 3 cycles with random inputs, then release → `valid_o=0`, `ready_o=1`, `unpacked_o=0`.
- Full word: `packed_i=8'b11_10_01_00`, `count_i=4`, `ready_i=1` → outputs 0,1,2,3 on consecutive cycles; `last_o` only on 3; `flush_o=0`.
- Back-to-back: words 0xE4 then 0x1B, each with count 4, `valid_i` held high → 8 consecutive elements 0,1,2,3,3,2,1,0 with no gap; `ready_o` high only on the last-lane cycles.
- Flushed partial: `packed_i=8'b00_00_10_01`, `count_i=2`, `flush_i=1` → outputs 1 then 2; `last_o=flush_o=1` on 2; next input is accepted that cycle.
- Edge counts:
  - `count_i=0` → no output, `ready_o` stays 1.
  - `count_i=7` → treated as 4; exactly 4 outputs.
- Backpressure and reset:
  - Random `ready_i` at 30% high → outputs are in order with none lost.
  - Asserting `reset_ni=0` mid-word (lane 2) → `valid_o=0` immediately and the next word starts clean at lane 0.
